// File: rtl/fsm_state_seq_pkg.sv
// ============================================================================
// Module   : fsm_pkg
// Purpose  : Shared state encoding for the microcoded control sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fsm_pkg;

  localparam int NSTATES = 13;

  typedef enum logic [3:0] {
    S0  = 4'd0,
    S1  = 4'd1,
    S2  = 4'd2,
    S3  = 4'd3,
    S4  = 4'd4,
    S5  = 4'd5,
    S6  = 4'd6,
    S7  = 4'd7,
    S8  = 4'd8,
    S9  = 4'd9,
    S10 = 4'd10,
    S11 = 4'd11,
    S12 = 4'd12
  } state_t;

  localparam state_t LAST_STATE = S12;

endpackage

`default_nettype wire

// File: rtl/fsm_state_seq_if.sv
// ============================================================================
// Module   : fsm_state_seq_if
// Purpose  : Link between the next-state logic (master) and the state stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fsm_state_seq_if #(
  parameter int NSTATES = fsm_pkg::NSTATES,
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
);

  logic [3:0]         next;
  logic               en;
  logic [3:0]         state_out;
  logic [NSTATES-1:0] state_onehot;
  logic               entered;
  logic [DWELL_W-1:0] dwell;
  logic               timeout;
  logic               illegal_err;
  logic [CNT_W-1:0]   done_cnt;

  modport master (
    output next, en,
    input  state_out, state_onehot, entered, dwell, timeout, illegal_err, done_cnt
  );

  modport slave (
    input  next, en,
    output state_out, state_onehot, entered, dwell, timeout, illegal_err, done_cnt
  );

endinterface

`default_nettype wire

// File: rtl/fsm_state_seq_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter with synchronous clear that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fsm_state_seq.sv
// ============================================================================
// Module   : fsm_state_seq
// Purpose  : Current-state register of the control FSM with stall, illegal
//            code recovery, dwell timeout and completed-pass counting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_state_seq
  import fsm_pkg::state_t;
  import fsm_pkg::S0;
#(
  parameter int NSTATES = fsm_pkg::NSTATES,
  parameter int DWELL_W = 8,
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  fsm_state_seq_if.slave    bus
);

  localparam logic [3:0]         c_LAST     = 4'(NSTATES - 1);
  localparam logic [DWELL_W-1:0] c_TMO_LAST = DWELL_W'(TIMEOUT - 1);

  state_t             r_state;
  logic               r_entered;
  logic               r_timeout;
  logic               r_illegal_err;
  logic [CNT_W-1:0]   r_done_cnt;
  logic [DWELL_W-1:0] w_dwell;

  logic w_illegal;
  logic w_change;
  logic w_force_tmo;
  logic w_wrap;

  assign w_illegal   = bus.en && (bus.next > c_LAST);
  assign w_change    = bus.en && (bus.next != r_state);
  // Timeout only applies while the state would otherwise stay put
  assign w_force_tmo = (w_dwell == c_TMO_LAST) && !w_change;
  assign w_wrap      = (r_state == c_LAST) && (bus.next == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S0;
      r_entered     <= 1'b1;
      r_timeout     <= 1'b0;
      r_illegal_err <= 1'b0;
      r_done_cnt    <= '0;
    end else begin
      r_entered <= 1'b0;
      r_timeout <= 1'b0;
      if (w_illegal) begin
        r_state       <= S0;
        r_illegal_err <= 1'b1;
        r_entered     <= 1'b1;
      end else if (w_force_tmo) begin
        r_state   <= S0;
        r_timeout <= 1'b1;
        r_entered <= 1'b1;
      end else if (w_change) begin
        r_state   <= state_t'(bus.next);
        r_entered <= 1'b1;
        if (w_wrap) begin
          r_done_cnt <= r_done_cnt + 1'b1;
        end
      end
    end
  end

  sat_counter #(
    .W (DWELL_W)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_illegal | w_force_tmo | w_change),
    .inc   (1'b1),
    .count (w_dwell)
  );

  for (genvar i = 0; i < NSTATES; i++) begin : g_onehot
    assign bus.state_onehot[i] = (r_state == 4'(i));
  end

  assign bus.state_out   = r_state;
  assign bus.entered     = r_entered;
  assign bus.dwell       = w_dwell;
  assign bus.timeout     = r_timeout;
  assign bus.illegal_err = r_illegal_err;
  assign bus.done_cnt    = r_done_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fsm_state_seq.sv
// ============================================================================
// Module   : tb_fsm_state_seq
// Purpose  : Directed self-checking bench for fsm_state_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_state_seq;

  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  fsm_state_seq_if #(.NSTATES(13), .DWELL_W(8), .CNT_W(8)) bus ();

  fsm_state_seq #(
    .NSTATES (13),
    .DWELL_W (8),
    .TIMEOUT (TMO),
    .CNT_W   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [3:0] n);
    bus.en   = e;
    bus.next = n;
    tick();
  endtask

  task automatic do_reset();
    bus.en   = 1'b0;
    bus.next = 4'd0;
    rst_n    = 1'b0;
    tick();
    rst_n    = 1'b1;
  endtask

  task automatic test_reset();
    bus.en   = 1'b0;
    bus.next = 4'd0;
    rst_n    = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.state_out !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus.state_out); end
    n_checks++; if (bus.state_onehot !== 13'h0001) begin n_fail++; $display("FAIL reset_onehot: got %h want 0001", bus.state_onehot); end
    n_checks++; if (bus.timeout !== 1'b0 || bus.illegal_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got tmo=%b ill=%b want 0 0", bus.timeout, bus.illegal_err); end
    n_checks++; if (bus.done_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_done: got %0d want 0", bus.done_cnt); end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (bus.dwell !== 8'(k)) begin n_fail++; $display("FAIL reset_dwell: got %0d want %0d", bus.dwell, k); end
      n_checks++; if (bus.entered !== (k == 0)) begin n_fail++; $display("FAIL reset_entered: got %b want %b", bus.entered, (k == 0)); end
      if (k < 2) tick();
    end
  endtask

  task automatic test_full_pass();
    logic [3:0] exp;
    for (int s = 0; s < 13; s++) begin
      exp = (s == 12) ? 4'd0 : 4'(s + 1);
      drive(1'b1, exp);
      n_checks++; if (bus.state_out !== exp) begin n_fail++; $display("FAIL pass_state: got %0d want %0d", bus.state_out, exp); end
      n_checks++; if (bus.state_onehot !== (13'd1 << exp)) begin n_fail++; $display("FAIL pass_onehot: got %h want %h", bus.state_onehot, 13'd1 << exp); end
      n_checks++; if (bus.entered !== 1'b1 || bus.dwell !== 8'd0) begin n_fail++; $display("FAIL pass_entered: got ent=%b dwell=%0d want 1 0", bus.entered, bus.dwell); end
      n_checks++; if (bus.done_cnt !== ((s == 12) ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL pass_done: got %0d want %0d", bus.done_cnt, (s == 12) ? 1 : 0); end
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 4'd5);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 4'd9);
      n_checks++; if (bus.state_out !== 4'd5 || bus.entered !== 1'b0) begin n_fail++; $display("FAIL stall_hold: got st=%0d ent=%b want 5 0", bus.state_out, bus.entered); end
      n_checks++; if (bus.dwell !== 8'(k)) begin n_fail++; $display("FAIL stall_dwell: got %0d want %0d", bus.dwell, k); end
    end
    drive(1'b1, 4'd6);
    n_checks++; if (bus.state_out !== 4'd6 || bus.dwell !== 8'd0 || bus.entered !== 1'b1) begin n_fail++; $display("FAIL stall_resume: got st=%0d dwell=%0d ent=%b want 6 0 1", bus.state_out, bus.dwell, bus.entered); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 4'd4);
    drive(1'b1, 4'd14);
    n_checks++; if (bus.state_out !== 4'd0 || bus.illegal_err !== 1'b1) begin n_fail++; $display("FAIL illegal_recover: got st=%0d ill=%b want 0 1", bus.state_out, bus.illegal_err); end
    n_checks++; if (bus.entered !== 1'b1 || bus.timeout !== 1'b0 || bus.done_cnt !== 8'd1) begin n_fail++; $display("FAIL illegal_side: got ent=%b tmo=%b done=%0d want 1 0 1", bus.entered, bus.timeout, bus.done_cnt); end
    drive(1'b1, 4'd12);
    drive(1'b1, 4'd0);
    n_checks++; if (bus.illegal_err !== 1'b1 || bus.done_cnt !== 8'd2) begin n_fail++; $display("FAIL illegal_sticky: got ill=%b done=%0d want 1 2", bus.illegal_err, bus.done_cnt); end
    drive(1'b1, 4'd12);
    drive(1'b1, 4'd15);
    n_checks++; if (bus.state_out !== 4'd0 || bus.done_cnt !== 8'd2) begin n_fail++; $display("FAIL illegal_from_last: got st=%0d done=%0d want 0 2", bus.state_out, bus.done_cnt); end
  endtask

  task automatic test_timeout();
    drive(1'b1, 4'd7);
    repeat (TMO - 1) drive(1'b0, 4'd0);
    n_checks++; if (bus.state_out !== 4'd7 || bus.dwell !== 8'(TMO - 1) || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_before: got st=%0d dwell=%0d tmo=%b want 7 %0d 0", bus.state_out, bus.dwell, bus.timeout, TMO - 1); end
    drive(1'b0, 4'd0);
    n_checks++; if (bus.state_out !== 4'd0 || bus.timeout !== 1'b1 || bus.entered !== 1'b1 || bus.dwell !== 8'd0) begin n_fail++; $display("FAIL tmo_fire: got st=%0d tmo=%b ent=%b dwell=%0d want 0 1 1 0", bus.state_out, bus.timeout, bus.entered, bus.dwell); end
    drive(1'b0, 4'd0);
    n_checks++; if (bus.timeout !== 1'b0 || bus.dwell !== 8'd1 || bus.done_cnt !== 8'd2) begin n_fail++; $display("FAIL tmo_pulse: got tmo=%b dwell=%0d done=%0d want 0 1 2", bus.timeout, bus.dwell, bus.done_cnt); end
    // en=1 with next equal to current state is still a stuck state
    drive(1'b1, 4'd7);
    repeat (TMO) drive(1'b1, 4'd7);
    n_checks++; if (bus.state_out !== 4'd0 || bus.timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_selfloop: got st=%0d tmo=%b want 0 1", bus.state_out, bus.timeout); end
    do_reset();
    drive(1'b1, 4'd7);
    repeat (TMO - 1) drive(1'b0, 4'd0);
    drive(1'b1, 4'd14);
    n_checks++; if (bus.state_out !== 4'd0 || bus.illegal_err !== 1'b1 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_vs_illegal: got st=%0d ill=%b tmo=%b want 0 1 0", bus.state_out, bus.illegal_err, bus.timeout); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) begin
      drive(1'b1, 4'd12);
      drive(1'b1, 4'd0);
    end
    drive(1'b1, 4'd9);
    n_checks++; if (bus.state_out !== 4'd9 || bus.done_cnt !== 8'd3) begin n_fail++; $display("FAIL async_setup: got st=%0d done=%0d want 9 3", bus.state_out, bus.done_cnt); end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.state_out !== 4'd0 || bus.done_cnt !== 8'd0 || bus.state_onehot !== 13'h0001) begin n_fail++; $display("FAIL async_reset: got st=%0d done=%0d oh=%h want 0 0 0001", bus.state_out, bus.done_cnt, bus.state_onehot); end
    n_checks++; if (bus.entered !== 1'b1 || bus.dwell !== 8'd0 || bus.illegal_err !== 1'b0) begin n_fail++; $display("FAIL async_flags: got ent=%b dwell=%0d ill=%b want 1 0 0", bus.entered, bus.dwell, bus.illegal_err); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.en   = 1'b0;
    bus.next = 4'd0;
    test_reset();
    test_full_pass();
    test_stall();
    test_illegal();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fsm_state_seq.md
# fsm_state_seq

State-holding stage of the microcoded control FSM. Sits directly downstream of the next-state logic: it registers the 4-bit `next` code into the current state, drives that state back as the next-state block's `state_in`, and decodes it for the datapath. It also supervises the sequence with:
- stall control;
- illegal-state recovery;
- a per-state dwell timeout;
- a completed-pass counter.

## Interface
Parameters:
- NSTATES, 13, number of legal states (codes 0..NSTATES-1)
- DWELL_W, 8, width of dwell counter
- TIMEOUT, 200, dwell cycles after which a stuck state is forced to S0 (2..2^DWELL_W-1)
- CNT_W, 8, width of completed-pass counter

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- next  in  4  next-state code from next-state logic
- en  in  1  1 = load `next` this edge; 0 = hold current state
- state_out  out  4  current state, fed to next-state logic `state_in`
- state_onehot  out  NSTATES  one-hot decode of state_out
- entered  out  1  one-cycle pulse in the first cycle of a new state
- dwell  out  DWELL_W  cycles spent in current state, 0 in first cycle, saturating
- timeout  out  1  one-cycle pulse in the cycle after a forced timeout restart
- illegal_err  out  1  sticky; set on an out-of-range `next`, cleared only by reset
- done_cnt  out  CNT_W  count of S(NSTATES-1)→S0 transitions, wraps

## Operation
- **Reset (rst_n=0, asynchronous):**
  - state_out=0 and state_onehot=1.
  - entered=1 for the first cycle after reset release, i.e. the entry into S0.
  - dwell=0, timeout=0, illegal_err=0, done_cnt=0.
- **Update rule per rising edge, in priority order:**
  1. en=1 and next>=NSTATES: state←0, illegal_err←1, entered←1, dwell←0.
  2. dwell==TIMEOUT-1 and the state would not change (en=0, or en=1 with next==state_out): state←0, timeout←1, entered←1, dwell←0.
  3. en=1 and next!=state_out: state←next, entered←1, dwell←0.
  4. Otherwise: state holds, entered←0, dwell←dwell+1 saturating at 2^DWELL_W-1.
- **done_cnt:** increments when state goes from NSTATES-1 to 0 via rule 3 only. Forced restarts (rules 1 and 2) do not count. Wraps modulo 2^CNT_W.
- **state_onehot:** combinational decode of state_out. All-zero is impossible because the register never holds an illegal code.
- **timeout:** pulses only after a rule-2 edge. It is 0 on every other edge.

## Timing
- Next-state logic output settles after the edge that produced it. This block samples `next` on the following rising edge, giving one state per cycle when en=1.
- Latency:
  - next → state_out: 1 cycle.
  - state_out → state_onehot: combinational.
  - entered and timeout: registered, aligned with the new state_out.
- en=0 freezes the state indefinitely, except that rule 2 forces S0 after TIMEOUT cycles in the same state.
- Simultaneous illegal `next` and timeout: rule 1 wins. illegal_err is set and timeout stays 0.
- rst_n asserted mid-sequence: all outputs return to their reset values immediately, regardless of clk.

## Structure
- **Shared package `fsm_pkg`:**
  - `state_t` (logic [3:0]);
  - constants S0..S12;
  - NSTATES;
  - LAST_STATE (= S12).
- **Sub-module `sat_counter`** (parametric width, synchronous clear, increment, saturate). Used for dwell.
- done_cnt is a plain wrapping counter inside the top module.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles, then release. Expect state_out=0, state_onehot=13'h0001, entered=1 for 1 cycle, then dwell counts 0,1,2.
- **Full pass:** en=1 with next=state_out+1, and next=0 from S12. Expect state_out 0..12 then 0, entered=1 every cycle, done_cnt=1 after the 12→0 edge.
- **Stall:** in S5, en=0 for 5 cycles. Expect state_out=5, dwell=0..5, entered=0. Then en=1, next=6: state_out=6, dwell=0.
- **Illegal:** in S4, next=14, en=1. Expect state_out=0, illegal_err=1 held until reset, done_cnt unchanged.
- **Timeout:** in S7 with en=0 for TIMEOUT cycles. Expect state_out=0 and a 1-cycle timeout pulse on cycle TIMEOUT. Repeat with next=14 on that same edge: expect illegal_err=1 and timeout=0.
- **Async reset mid-run:** drop rst_n between edges while in S9 with done_cnt=3. Expect state_out=0 and done_cnt=0 before the next clk edge.
